// File: rtl/bsg_manycore_endpoint_tx_mux_pkg.sv
// Shared types and widths for the endpoint TX mux and its tag allocator.
package bsg_manycore_endpoint_tx_mux_pkg;

   localparam int bsg_manycore_reg_id_width_gp          = 5;
   localparam int bsg_manycore_return_pkt_type_width_gp = 2;
   localparam int tx_mux_chan_id_width_gp               = 4;

   // One in-flight tag: which channel owns it and the reg_id that channel originally used.
   typedef struct packed {
      logic [tx_mux_chan_id_width_gp-1:0]      chan_id;
      logic [bsg_manycore_reg_id_width_gp-1:0] reg_id;
   } tx_mux_tag_entry_s;

   function automatic int safe_clog2(input int x);
      return (x > 1) ? $clog2(x) : 1;
   endfunction

endpackage

// File: rtl/bsg_manycore_endpoint_tx_mux_tag_alloc.sv
// Tag free list with lowest-index allocation, plus the tag -> {channel, reg_id} table.
module bsg_manycore_tag_alloc
   import bsg_manycore_endpoint_tx_mux_pkg::*;
#(
   parameter int num_tags_p = 16,
   localparam int tag_width_lp = safe_clog2(num_tags_p)
) (
   input  logic                                     clk_i,
   input  logic                                     reset_n_i,
   input  logic                                     alloc_v_i,
   input  tx_mux_tag_entry_s                        alloc_entry_i,
   output logic                                     alloc_avail_o,
   output logic [tag_width_lp-1:0]                  alloc_tag_o,
   input  logic [bsg_manycore_reg_id_width_gp-1:0]  lookup_tag_i,
   output logic                                     lookup_busy_o,
   output tx_mux_tag_entry_s                        lookup_entry_o,
   input  logic                                     free_v_i
);

   logic [num_tags_p-1:0] free_q, free_d;
   tx_mux_tag_entry_s     table_q [num_tags_p];
   logic                  found;
   logic                  in_range;
   logic [tag_width_lp-1:0] lookup_idx;

   always_comb begin
      alloc_avail_o = |free_q;
      alloc_tag_o   = '0;
      found         = 1'b0;
      for (int i = 0; i < num_tags_p; i++) begin
         if (!found && free_q[i]) begin
            alloc_tag_o = tag_width_lp'(i);
            found       = 1'b1;
         end
      end
   end

   // Tags outside the table are never allocated, so they look like free tags to the caller.
   always_comb begin
      in_range       = (int'(lookup_tag_i) < num_tags_p);
      lookup_idx     = lookup_tag_i[tag_width_lp-1:0];
      lookup_busy_o  = 1'b0;
      lookup_entry_o = '0;
      if (in_range) begin
         lookup_busy_o  = ~free_q[lookup_idx];
         lookup_entry_o = table_q[lookup_idx];
      end
   end

   always_comb begin
      free_d = free_q;
      if (free_v_i && lookup_busy_o) free_d[lookup_idx] = 1'b1;
      if (alloc_v_i && alloc_avail_o) free_d[alloc_tag_o] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         free_q <= '1;
         for (int i = 0; i < num_tags_p; i++) table_q[i] <= '0;
      end else begin
         free_q <= free_d;
         if (alloc_v_i && alloc_avail_o) table_q[alloc_tag_o] <= alloc_entry_i;
      end
   end

endmodule

// File: rtl/bsg_manycore_endpoint_tx_mux.sv
// Round-robin mux of several requesters onto one endpoint TX port, with reg_id tag rewriting
// and return routing back to the owning channel.
module bsg_manycore_endpoint_tx_mux
   import bsg_manycore_endpoint_tx_mux_pkg::*;
#(
   parameter int num_chan_p        = 2,
   parameter int num_tags_p        = 16,
   parameter int max_outstanding_p = 8,
   parameter int data_width_p      = 32,
   parameter int packet_width_p    = 64,
   parameter int reg_id_lsb_p      = 8,
   localparam int reg_id_w_lp      = bsg_manycore_reg_id_width_gp,
   localparam int pkt_type_w_lp    = bsg_manycore_return_pkt_type_width_gp,
   localparam int cnt_w_lp         = $clog2(max_outstanding_p + 1),
   localparam int chan_w_lp        = safe_clog2(num_chan_p),
   localparam int tag_w_lp         = safe_clog2(num_tags_p)
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic [num_chan_p-1:0]                req_v_i,
   input  logic [num_chan_p*packet_width_p-1:0] req_packet_i,
   output logic [num_chan_p-1:0]                req_ready_o,
   output logic                                 out_v_o,
   output logic [packet_width_p-1:0]            out_packet_o,
   input  logic                                 out_credit_or_ready_i,
   input  logic                                 returned_v_i,
   input  logic [data_width_p-1:0]              returned_data_i,
   input  logic [reg_id_w_lp-1:0]               returned_reg_id_i,
   input  logic [pkt_type_w_lp-1:0]             returned_pkt_type_i,
   output logic                                 returned_yumi_o,
   output logic [num_chan_p-1:0]                resp_v_o,
   output logic [data_width_p-1:0]              resp_data_o,
   output logic [reg_id_w_lp-1:0]               resp_reg_id_o,
   output logic [pkt_type_w_lp-1:0]             resp_pkt_type_o,
   input  logic [num_chan_p-1:0]                resp_yumi_i,
   output logic [num_chan_p*cnt_w_lp-1:0]       outstanding_o,
   output logic                                 err_unalloc_tag_o
);

   logic [cnt_w_lp-1:0]       cnt_q [num_chan_p];
   logic [cnt_w_lp-1:0]       cnt_d [num_chan_p];
   logic [chan_w_lp-1:0]      rr_q, rr_d;
   logic                      err_q, err_d;
   logic [num_chan_p-1:0]     eligible;
   logic                      grant_v;
   logic [chan_w_lp-1:0]      grant_ch;
   logic [packet_width_p-1:0] grant_pkt;
   logic                      alloc_avail;
   logic [tag_w_lp-1:0]       alloc_tag;
   tx_mux_tag_entry_s         alloc_entry;
   tx_mux_tag_entry_s         lookup_entry;
   logic                      lookup_busy;
   logic                      ret_hit;
   logic                      owner_yumi;
   logic                      free_v;

   bsg_manycore_tag_alloc #(.num_tags_p(num_tags_p)) tag_alloc (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .alloc_v_i     (grant_v),
      .alloc_entry_i (alloc_entry),
      .alloc_avail_o (alloc_avail),
      .alloc_tag_o   (alloc_tag),
      .lookup_tag_i  (returned_reg_id_i),
      .lookup_busy_o (lookup_busy),
      .lookup_entry_o(lookup_entry),
      .free_v_i      (free_v)
   );

   // Outputs are gated by reset so nothing handshakes while state is being cleared.
   always_comb begin
      grant_v  = 1'b0;
      grant_ch = '0;
      for (int ch = 0; ch < num_chan_p; ch++)
         eligible[ch] = req_v_i[ch] && (cnt_q[ch] < cnt_w_lp'(max_outstanding_p));
      if (reset_n_i && out_credit_or_ready_i && alloc_avail) begin
         for (int i = 0; i < num_chan_p; i++) begin
            if (!grant_v && eligible[(int'(rr_q) + i) % num_chan_p]) begin
               grant_v  = 1'b1;
               grant_ch = chan_w_lp'((int'(rr_q) + i) % num_chan_p);
            end
         end
      end
      for (int ch = 0; ch < num_chan_p; ch++)
         req_ready_o[ch] = grant_v && (int'(grant_ch) == ch);
   end

   always_comb begin
      grant_pkt    = req_packet_i[int'(grant_ch)*packet_width_p +: packet_width_p];
      out_v_o      = grant_v;
      out_packet_o = grant_pkt;
      out_packet_o[reg_id_lsb_p +: reg_id_w_lp] = reg_id_w_lp'(alloc_tag);
      alloc_entry.chan_id = tx_mux_chan_id_width_gp'(grant_ch);
      alloc_entry.reg_id  = grant_pkt[reg_id_lsb_p +: reg_id_w_lp];
   end

   // A return on a free tag is swallowed so the endpoint never stalls on a stray packet.
   always_comb begin
      ret_hit    = reset_n_i && returned_v_i && lookup_busy;
      owner_yumi = 1'b0;
      for (int ch = 0; ch < num_chan_p; ch++) begin
         resp_v_o[ch] = ret_hit && (int'(lookup_entry.chan_id) == ch);
         owner_yumi   = owner_yumi | (resp_v_o[ch] & resp_yumi_i[ch]);
      end
      returned_yumi_o = reset_n_i && returned_v_i && (lookup_busy ? owner_yumi : 1'b1);
      free_v          = ret_hit && owner_yumi;
      resp_data_o     = returned_data_i;
      resp_reg_id_o   = lookup_entry.reg_id;
      resp_pkt_type_o = returned_pkt_type_i;
      err_d           = err_q | (reset_n_i && returned_v_i && !lookup_busy);
   end

   always_comb begin
      rr_d = rr_q;
      if (grant_v)
         rr_d = (int'(grant_ch) == num_chan_p - 1) ? '0 : grant_ch + chan_w_lp'(1);
      for (int ch = 0; ch < num_chan_p; ch++) begin
         cnt_d[ch] = cnt_q[ch];
         if (req_ready_o[ch] && !(free_v && int'(lookup_entry.chan_id) == ch))
            cnt_d[ch] = cnt_q[ch] + cnt_w_lp'(1);
         else if (!req_ready_o[ch] && free_v && int'(lookup_entry.chan_id) == ch)
            cnt_d[ch] = cnt_q[ch] - cnt_w_lp'(1);
         outstanding_o[ch*cnt_w_lp +: cnt_w_lp] = cnt_q[ch];
      end
      err_unalloc_tag_o = err_q;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rr_q  <= '0;
         err_q <= 1'b0;
         for (int ch = 0; ch < num_chan_p; ch++) cnt_q[ch] <= '0;
      end else begin
         rr_q  <= rr_d;
         err_q <= err_d;
         for (int ch = 0; ch < num_chan_p; ch++) cnt_q[ch] <= cnt_d[ch];
      end
   end

endmodule
